// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
// master: lock source and software reset requester; slave: the sequencer.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  locked;
  logic                  sw_reset;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  rst_done;
  logic [1:0]            state;
  logic [7:0]            abort_cnt;

  modport master (
    output locked, sw_reset,
    input  rst_out, rst_done, state, abort_cnt
  );

  modport slave (
    input  locked, sw_reset,
    output rst_out, rst_done, state, abort_cnt
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order once a filtered lock is seen;
// lock loss or sw_reset re-asserts every stage on the same edge.
module reset_sequencer #(
  parameter int NUM_STAGES    = 3,
  parameter int HOLD_CYCLES   = 8,
  parameter int LOCK_FILTER   = 4,
  parameter int RELEASE_DELAY = 16,
  parameter int SYNC_STAGE    = 3
) (
  input  logic             clk,
  input  logic             areset,
  reset_sequencer_if.slave bus
);

  localparam int MAX_HL  = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
  localparam int MAX_CNT = (MAX_HL > RELEASE_DELAY) ? MAX_HL : RELEASE_DELAY;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                st;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] rst_q;
  logic                  done_q;
  logic [7:0]            abort_q;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;
  logic locked_s;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGE-2:0], bus.locked};
  end

  assign locked_s = sync_q[SYNC_STAGE-1];

  // Lock loss only counts once sequencing has started; earlier it just stalls the filter.
  logic lock_abort, sw_abort;
  assign lock_abort = ((st == S_RELEASE) || (st == S_RUN)) && !locked_s;
  assign sw_abort   = bus.sw_reset && (st != S_RESET);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      st      <= S_RESET;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      abort_q <= '0;
    end else begin
      if (lock_abort && (abort_q != 8'hFF)) abort_q <= abort_q + 8'd1;

      if (lock_abort || sw_abort) begin
        st     <= S_RESET;
        cnt    <= '0;
        idx    <= '0;
        rst_q  <= '1;
        done_q <= 1'b0;
      end else begin
        case (st)
          S_RESET: begin
            if (bus.sw_reset) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              st  <= S_WAIT_LOCK;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (!locked_s) begin
              cnt <= '0;
            end else if (cnt == LOCK_LAST) begin
              st  <= S_RELEASE;
              cnt <= '0;
              idx <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (cnt == REL_LAST) begin
              cnt <= '0;
              idx <= idx + 1'b1;
              for (int i = 0; i < NUM_STAGES; i++)
                if (idx == IDX_W'(i)) rst_q[i] <= 1'b0;
              if (idx == IDX_LAST) begin
                st     <= S_RUN;
                done_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: done_q <= 1'b1;
          default: st <= S_RESET;
        endcase
      end
    end
  end

  assign bus.rst_out   = rst_q;
  assign bus.rst_done  = done_q;
  assign bus.state     = st;
  assign bus.abort_cnt = abort_q;

endmodule
